// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multicycle core control path.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_LLI   = 5'b00001;
  localparam logic [4:0] OP_LHI   = 5'b00010;
  localparam logic [4:0] OP_LDRRI = 5'b00011;
  localparam logic [4:0] OP_LDRRR = 5'b00100;
  localparam logic [4:0] OP_STRRI = 5'b00101;
  localparam logic [4:0] OP_STRRR = 5'b00110;
  localparam logic [4:0] OP_OUTR  = 5'b00111;
  localparam logic [4:0] OP_BZ    = 5'b01000;
  localparam logic [4:0] OP_BNZ   = 5'b01001;
  localparam logic [4:0] OP_BC    = 5'b01010;
  localparam logic [4:0] OP_BNC   = 5'b01011;
  localparam logic [4:0] OP_JMP   = 5'b01100;
  localparam logic [4:0] OP_JR    = 5'b01101;
  localparam logic [4:0] OP_HLT   = 5'b11111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_ADC = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SBB = 2'b11;

  localparam int PSW_N = 2;
  localparam int PSW_Z = 1;
  localparam int PSW_C = 0;

  localparam logic [1:0] JUMP_PC1 = 2'b00;
  localparam logic [1:0] JUMP_IMM = 2'b01;
  localparam logic [1:0] JUMP_RB  = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic       buff_mem_ins;
    logic       alu_or_not;
    logic       li_or_mov;
    logic       mem_resource;
    logic       we_mem;
    logic       wb_resource;
    logic       rb_resource;
    logic       oprand_b;
    logic       li;
    logic       pc_plus1_or_wb;
    logic       we_rf;
    logic       flag;
    logic       alu_op;
    logic       buff_psw;
    logic       branch;
    logic [1:0] jump;
    logic       buff_pc;
    logic       done;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic op_defined(input logic [4:0] op);
    return (op <= OP_JR) || (op == OP_HLT);
  endfunction

  function automatic logic op_flow(input logic [4:0] op);
    return (op >= OP_BZ) && (op <= OP_JR);
  endfunction

  function automatic logic op_str(input logic [4:0] op);
    return (op == OP_STRRI) || (op == OP_STRRR);
  endfunction

  function automatic logic op_ldr(input logic [4:0] op);
    return (op == OP_LDRRI) || (op == OP_LDRRR);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from FSM state, opcode, ALU sub-op and flags.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic [1:0] alu_sel,
  input  logic [2:0] psw,
  output ctrl_word_t ctrl
);

  // N is carried in the flag bus but no branch tests it
  logic unused_psw_n;
  assign unused_psw_n = psw[PSW_N];

  // Per-state control word; anything not driven stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: ctrl.buff_mem_ins = 1'b1;
      S_ID: begin
        if (!op_defined(opcode)) begin
          ctrl.illegal = 1'b1;
          ctrl.buff_pc = !HALT_ON_ILLEGAL;
        end else begin
          case (opcode)
            OP_LDRRI, OP_STRRI: ctrl.oprand_b = 1'b1;
            OP_LHI: begin
              ctrl.rb_resource = 1'b1;
              ctrl.li          = 1'b1;
            end
            OP_OUTR, OP_HLT: ctrl.buff_pc = 1'b1;
            default: ;
          endcase
        end
      end
      S_EX: begin
        case (opcode)
          OP_ALU: begin
            // ADC/SBB use carry (sub-op bit 0), SUB/SBB subtract (bit 1)
            ctrl.flag     = alu_sel[0];
            ctrl.alu_op   = alu_sel[1];
            ctrl.buff_psw = 1'b1;
          end
          OP_STRRI, OP_STRRR: ctrl.rb_resource = 1'b1;
          OP_BZ: begin
            ctrl.buff_pc = 1'b1;
            ctrl.branch  = psw[PSW_Z];
          end
          OP_BNZ: begin
            ctrl.buff_pc = 1'b1;
            ctrl.branch  = !psw[PSW_Z];
          end
          OP_BC: begin
            ctrl.buff_pc = 1'b1;
            ctrl.branch  = psw[PSW_C];
          end
          OP_BNC: begin
            ctrl.buff_pc = 1'b1;
            ctrl.branch  = !psw[PSW_C];
          end
          OP_JMP: begin
            ctrl.buff_pc = 1'b1;
            ctrl.jump    = JUMP_IMM;
          end
          OP_JR: begin
            ctrl.buff_pc = 1'b1;
            ctrl.jump    = JUMP_RB;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LLI || opcode == OP_LHI) ctrl.alu_or_not = 1'b1;
        if (op_ldr(opcode)) ctrl.mem_resource = 1'b1;
        if (op_str(opcode)) begin
          ctrl.mem_resource = 1'b1;
          ctrl.we_mem       = 1'b1;
          ctrl.buff_pc      = 1'b1;
        end
      end
      S_WB: begin
        ctrl.we_rf          = 1'b1;
        ctrl.pc_plus1_or_wb = 1'b1;
        ctrl.buff_pc        = 1'b1;
        ctrl.wb_resource    = op_ldr(opcode);
      end
      S_HALT: ctrl.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle core sequencer: state register and next-state logic.
// state | meaning
// IF    | fetch instruction into IR
// ID    | decode, short instructions retire here
// EX    | ALU op / address calc / branch resolve
// MEM   | memory access or immediate select
// WB    | register-file write and PC advance
// HALT  | stopped after HLT, left only by reset
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [4:0] opcode,
  input  logic [1:0] ALUopcode,
  input  logic [2:0] PSW_NZC,
  output logic       Buff_MEMIns,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       MEMresource,
  output logic       WE_MEM,
  output logic       WBresource,
  output logic       RBresource,
  output logic       oprandB,
  output logic       LI,
  output logic       PCplus1orWB,
  output logic       WE_RF,
  output logic       Flag,
  output logic       ALUop,
  output logic       Buff_PSW,
  output logic       Branch,
  output logic [1:0] Jump,
  output logic       Buff_PC,
  output logic       done,
  output logic       illegal
);

  state_t     state, state_nxt;
  ctrl_word_t ctrl, ctrl_out;

  ctrl_decode #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_decode (
    .state   (state),
    .opcode  (opcode),
    .alu_sel (ALUopcode),
    .psw     (PSW_NZC),
    .ctrl    (ctrl)
  );

  // Reset silences the control word at once, even though the state already reads IF
  assign ctrl_out = Rst ? ctrl : '0;

  assign Buff_MEMIns = ctrl_out.buff_mem_ins;
  assign ALUorNot    = ctrl_out.alu_or_not;
  assign LIorMOV     = ctrl_out.li_or_mov;
  assign MEMresource = ctrl_out.mem_resource;
  assign WE_MEM      = ctrl_out.we_mem;
  assign WBresource  = ctrl_out.wb_resource;
  assign RBresource  = ctrl_out.rb_resource;
  assign oprandB     = ctrl_out.oprand_b;
  assign LI          = ctrl_out.li;
  assign PCplus1orWB = ctrl_out.pc_plus1_or_wb;
  assign WE_RF       = ctrl_out.we_rf;
  assign Flag        = ctrl_out.flag;
  assign ALUop       = ctrl_out.alu_op;
  assign Buff_PSW    = ctrl_out.buff_psw;
  assign Branch      = ctrl_out.branch;
  assign Jump        = ctrl_out.jump;
  assign Buff_PC     = ctrl_out.buff_pc;
  assign done        = ctrl_out.done;
  assign illegal     = ctrl_out.illegal;

  // Next-state selection per instruction class
  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        if (!op_defined(opcode))   state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF;
        else if (opcode == OP_OUTR) state_nxt = S_IF;
        else if (opcode == OP_HLT)  state_nxt = S_HALT;
        else                        state_nxt = S_EX;
      end
      S_EX:    state_nxt = op_flow(opcode) ? S_IF : S_MEM;
      S_MEM:   state_nxt = op_str(opcode) ? S_IF : S_WB;
      S_WB:    state_nxt = S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state <= S_IF;
    else      state <= state_nxt;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       Rst, rst1;
  logic [4:0] opcode, op1;
  logic [1:0] ALUopcode;
  logic [2:0] PSW_NZC;

  logic       a_bmi, a_aon, a_lim, a_mres, a_wem, a_wbr, a_rbr, a_opb, a_li, a_pcwb, a_werf;
  logic       a_flag, a_aluop, a_bpsw, a_br, a_bpc, a_done, a_ill;
  logic [1:0] a_jump;
  logic       b_bmi, b_aon, b_lim, b_mres, b_wem, b_wbr, b_rbr, b_opb, b_li, b_pcwb, b_werf;
  logic       b_flag, b_aluop, b_bpsw, b_br, b_bpc, b_done, b_ill;
  logic [1:0] b_jump;
  logic [19:0] act0, act1;

  always #5 clk = ~clk;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
    .Buff_MEMIns(a_bmi), .ALUorNot(a_aon), .LIorMOV(a_lim), .MEMresource(a_mres),
    .WE_MEM(a_wem), .WBresource(a_wbr), .RBresource(a_rbr), .oprandB(a_opb), .LI(a_li),
    .PCplus1orWB(a_pcwb), .WE_RF(a_werf), .Flag(a_flag), .ALUop(a_aluop), .Buff_PSW(a_bpsw),
    .Branch(a_br), .Jump(a_jump), .Buff_PC(a_bpc), .done(a_done), .illegal(a_ill)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .Rst(rst1), .opcode(op1), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
    .Buff_MEMIns(b_bmi), .ALUorNot(b_aon), .LIorMOV(b_lim), .MEMresource(b_mres),
    .WE_MEM(b_wem), .WBresource(b_wbr), .RBresource(b_rbr), .oprandB(b_opb), .LI(b_li),
    .PCplus1orWB(b_pcwb), .WE_RF(b_werf), .Flag(b_flag), .ALUop(b_aluop), .Buff_PSW(b_bpsw),
    .Branch(b_br), .Jump(b_jump), .Buff_PC(b_bpc), .done(b_done), .illegal(b_ill)
  );

  // bit 19..0: MEMIns ALUorNot LIorMOV MEMres WE_MEM WBres RBres oprandB LI PC1orWB WE_RF
  //            Flag ALUop Buff_PSW Branch Jump[1:0] Buff_PC done illegal
  assign act0 = {a_bmi, a_aon, a_lim, a_mres, a_wem, a_wbr, a_rbr, a_opb, a_li, a_pcwb, a_werf,
                 a_flag, a_aluop, a_bpsw, a_br, a_jump, a_bpc, a_done, a_ill};
  assign act1 = {b_bmi, b_aon, b_lim, b_mres, b_wem, b_wbr, b_rbr, b_opb, b_li, b_pcwb, b_werf,
                 b_flag, b_aluop, b_bpsw, b_br, b_jump, b_bpc, b_done, b_ill};

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [4:0] cur_op = '0;
  logic [1:0] cur_alu = '0;
  int cur_ph = 0;
  logic [19:0] last_act [0:7];
  logic [19:0] halt_act = '0;
  int wrf_cnt = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %05h want %05h (op=%05b ph=%0d t=%0t)", name, act, exp, cur_op, cur_ph, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Instruction length in cycles from the cycle-count table
  function automatic int ilen(input logic [4:0] op, input bit hoi);
    if (op <= 5'd4) return 5;
    if (op == 5'd5 || op == 5'd6) return 4;
    if (op >= 5'd8 && op <= 5'd13) return 3;
    if (op == 5'd7 || op == 5'd31) return 2;
    return hoi ? 2 : 2;
  endfunction

  // Expected control word for cycle ph (0 = fetch) of instruction op
  function automatic logic [19:0] model(input logic [4:0] op, input logic [1:0] alu,
                                        input logic [2:0] psw, input int ph, input bit hoi);
    logic [19:0] w;
    bit is_ldr, is_str, is_br, is_def, halts;
    w = '0;
    is_ldr = (op == 5'd3) || (op == 5'd4);
    is_str = (op == 5'd5) || (op == 5'd6);
    is_br  = (op >= 5'd8) && (op <= 5'd11);
    is_def = (op <= 5'd13) || (op == 5'd31);
    halts  = (op == 5'd31) || (!is_def && hoi);
    if (halts && ph >= 2) begin
      w[1] = 1'b1;
      return w;
    end
    case (ph)
      0: w[19] = 1'b1;
      1: begin
        w[12] = (op == 5'd3) || (op == 5'd5);
        w[13] = (op == 5'd2);
        w[11] = (op == 5'd2);
        w[2]  = (op == 5'd7) || (op == 5'd31) || (!is_def && !hoi);
        w[0]  = !is_def;
      end
      2: begin
        if (op == 5'd0) begin
          w[8] = (alu == 2'b01) || (alu == 2'b11);
          w[7] = (alu == 2'b10) || (alu == 2'b11);
          w[6] = 1'b1;
        end
        if (is_str) w[13] = 1'b1;
        if (is_br || op == 5'd12 || op == 5'd13) w[2] = 1'b1;
        if (op == 5'd8)  w[5] = psw[1];
        if (op == 5'd9)  w[5] = !psw[1];
        if (op == 5'd10) w[5] = psw[0];
        if (op == 5'd11) w[5] = !psw[0];
        if (op == 5'd12) w[4:3] = 2'b01;
        if (op == 5'd13) w[4:3] = 2'b10;
      end
      3: begin
        if (op == 5'd1 || op == 5'd2) w[18] = 1'b1;
        if (is_ldr) w[16] = 1'b1;
        if (is_str) begin
          w[16] = 1'b1;
          w[15] = 1'b1;
          w[2]  = 1'b1;
        end
      end
      4: begin
        w[9]  = 1'b1;
        w[10] = 1'b1;
        w[2]  = 1'b1;
        w[14] = is_ldr;
      end
      default: ;
    endcase
    return w;
  endfunction

  // Every cycle the bench says is meaningful, DUT output must match the model
  always @(negedge clk) begin
    if (chk_en) check("model", act0, model(cur_op, cur_alu, PSW_NZC, cur_ph, 1'b0));
  end

  // Runs one instruction from IF; abort_at >= 0 pulls reset mid-cycle in that phase
  task automatic run_instr(input logic [4:0] op, input logic [1:0] alu, input bit fixp,
                           input logic [2:0] pv, input int abort_at);
    int n;
    n = ilen(op, 1'b0);
    for (int ph = 0; ph < n; ph++) begin
      opcode = op;
      ALUopcode = alu;
      PSW_NZC = fixp ? pv : 3'($urandom_range(0, 7));
      cur_op = op;
      cur_alu = alu;
      cur_ph = ph;
      if (ph == abort_at) begin
        #2;
        chk_en = 1'b0;
        Rst = 1'b0;
        #1;
        check("abort_outs", act0, 20'h00000);
        @(posedge clk);
        #3;
        Rst = 1'b1;
        chk_en = 1'b1;
        return;
      end
      @(negedge clk);
      last_act[ph] = act0;
      wrf_cnt += int'(act0[9]);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_halt(input int n);
    for (int i = 0; i < n; i++) begin
      cur_ph = 2 + i;
      PSW_NZC = 3'($urandom_range(0, 7));
      @(negedge clk);
      halt_act = act0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    #2;
    chk_en = 1'b0;
    Rst = 1'b0;
    #1;
    check(name, act0, 20'h00000);
    @(posedge clk);
    #3;
    Rst = 1'b1;
    chk_en = 1'b1;
  endtask

  logic [4:0] defs [15];
  logic [4:0] rop;
  int ab;

  initial begin
    defs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
             5'd10, 5'd11, 5'd12, 5'd13, 5'd31};
    Rst = 1'b0; rst1 = 1'b0; opcode = '0; op1 = '0; ALUopcode = '0; PSW_NZC = '0;
    @(posedge clk);
    #1;
    check("reset_outs0", act0, 20'h00000);
    check("reset_outs1", act1, 20'h00000);

    // HALT_ON_ILLEGAL=1 instance: undefined opcode halts without loading PC
    #2;
    op1 = 5'b10101;
    rst1 = 1'b1;
    @(negedge clk); check("hoi_if", act1, model(op1, 2'b00, PSW_NZC, 0, 1'b1));
    @(posedge clk); #1;
    @(negedge clk); check("hoi_id", act1, 20'h00001);
    @(posedge clk); #1;
    @(negedge clk); check("hoi_halt", act1, 20'h00002);
    @(posedge clk); #1;
    @(negedge clk); check("hoi_stay", act1, model(op1, 2'b00, PSW_NZC, 3, 1'b1));
    rst1 = 1'b0;
    #1;
    check("hoi_rst", act1, 20'h00000);
    @(posedge clk); #3;
    Rst = 1'b1;
    chk_en = 1'b1;

    // ADC
    run_instr(5'd0, 2'b01, 1'b0, 3'b000, -1);
    check("adc_ex", last_act[2], 20'h00140);
    check("adc_wb", last_act[4], 20'h00604);
    // STRri then LDRri
    run_instr(5'd5, 2'b00, 1'b0, 3'b000, -1);
    check("str_mem", last_act[3], 20'h18004);
    run_instr(5'd3, 2'b00, 1'b0, 3'b000, -1);
    check("after_str_if", last_act[0], 20'h80000);
    check("ldr_wb", last_act[4], 20'h04604);
    // Branches and JR
    run_instr(5'd8, 2'b00, 1'b1, 3'b010, -1);
    check("bz_taken", last_act[2], 20'h00024);
    run_instr(5'd8, 2'b00, 1'b1, 3'b000, -1);
    check("bz_not", last_act[2], 20'h00004);
    run_instr(5'd13, 2'b00, 1'b0, 3'b000, -1);
    check("jr_ex", last_act[2], 20'h00014);
    // Undefined opcode as NOP
    run_instr(5'b10101, 2'b00, 1'b0, 3'b000, -1);
    check("illegal_id", last_act[1], 20'h00005);
    // Reset during EX of SUB
    run_instr(5'd0, 2'b10, 1'b0, 3'b000, 2);

    // Short program ending in HLT
    wrf_cnt = 0;
    cyc = 0;
    run_instr(5'd1, 2'b00, 1'b0, 3'b000, -1);
    run_instr(5'd2, 2'b00, 1'b0, 3'b000, -1);
    run_instr(5'd1, 2'b00, 1'b0, 3'b000, -1);
    run_instr(5'd0, 2'b10, 1'b0, 3'b000, -1);
    run_instr(5'd7, 2'b00, 1'b0, 3'b000, -1);
    run_instr(5'd0, 2'b11, 1'b0, 3'b000, -1);
    run_instr(5'd7, 2'b00, 1'b0, 3'b000, -1);
    run_instr(5'd31, 2'b00, 1'b0, 3'b000, -1);
    run_halt(1);
    check("prog_done", halt_act, 20'h00002);
    check_int("prog_we_rf", wrf_cnt, 5);
    check_int("prog_len", cyc, 31);
    run_halt(2);
    do_reset("halt_rst");

    // Random instruction stream
    for (int k = 0; k < 250; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      rop = (r < 15) ? defs[r] : 5'($urandom_range(0, 31));
      ab = -1;
      if ($urandom_range(0, 29) == 0) ab = int'($urandom_range(0, ilen(rop, 1'b0) - 1));
      run_instr(rop, 2'($urandom_range(0, 3)), 1'b0, 3'b000, ab);
      if (rop == 5'd31 && ab < 0) begin
        run_halt(int'($urandom_range(1, 3)));
        do_reset("rand_halt_rst");
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
